// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------------------------
// uart_tx
//
// 8N1 UART transmitter for the board rs_tx pin. Bytes are accepted on a valid/ready port into a
// small power-of-two FIFO, then a bit-timing FSM serialises each one as a start bit (0), eight
// data bits LSB first and a stop bit (1). Each bit lasts CLKS_PER_BIT clocks, so a frame is
// exactly 10*CLKS_PER_BIT clocks. When the FIFO still holds data at the end of a stop bit, the
// next frame starts on the following clock with no idle gap.
//
// Parameters
//   CLK_FREQ    input clock frequency in Hz
//   BAUD        line rate in bit/s
//   FIFO_DEPTH  queued-byte capacity (power of two, >= 2); one more byte fits in the shifter
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset; abandons any frame and flushes the FIFO
//   tx_data     byte to send, sampled only on an accepting edge
//   tx_valid    tx_data valid
//   tx_ready    FIFO not full (depends only on registered state)
//   tx          serial output, idle high, driven straight from a flop
//   busy        frame in progress or bytes still queued
//   fifo_count  bytes waiting in the FIFO (the byte being shifted is not counted)
// ---------------------------------------------------------------------------------------------

module uart_tx #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    // Rounded to the nearest integer so the bit period error stays under half a clock.
    localparam int unsigned CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    // Reject parameter sets the bit timer or pointer arithmetic cannot support.
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx: FIFO_DEPTH must be a power of two and at least 2");
    end

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_t;

    // -----------------------------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------------------------
    state_t               state_q;
    logic [CNT_W-1:0]     baud_cnt_q;
    logic [2:0]           bit_idx_q;
    logic [7:0]           shift_q;
    logic                 tx_q;

    logic [7:0]           mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [PTR_W:0]       count_q;

    // -----------------------------------------------------------------------------------------
    // Handshake and pop decode
    // -----------------------------------------------------------------------------------------
    logic push;
    logic pop;
    logic fifo_nonempty;
    logic bit_end;

    always_comb begin
        fifo_nonempty = (count_q != '0);
        bit_end       = (baud_cnt_q == CNT_LAST);
        push          = tx_valid && tx_ready;
        // A byte leaves the FIFO either from idle, or on the final stop-bit clock so the next
        // start bit follows with no gap. A byte pushed on this same edge is not yet visible.
        pop           = fifo_nonempty &&
                        ((state_q == StIdle) || ((state_q == StStop) && bit_end));
    end

    assign tx_ready   = (count_q != COUNT_FULL);
    assign tx         = tx_q;
    assign busy       = (state_q != StIdle) || fifo_nonempty;
    assign fifo_count = count_q;

    // -----------------------------------------------------------------------------------------
    // FIFO storage: data only, no reset needed since count_q gates every read.
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= tx_data;
        end
    end

    // -----------------------------------------------------------------------------------------
    // FIFO pointers/count and the bit-timing FSM with its registered line output
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            // Pointers wrap naturally because the depth is a power of two.
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q    <= mem[rd_ptr_q];
                        baud_cnt_q <= '0;
                        tx_q       <= 1'b0;
                        state_q    <= StStart;
                    end
                end

                StStart: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        tx_q       <= shift_q[0];
                        state_q    <= StData;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end

                StData: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            // Drive the next bit now so tx stays a pure flop output.
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end

                StStop: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        if (pop) begin
                            shift_q <= mem[rd_ptr_q];
                            tx_q    <= 1'b0;
                            state_q <= StStart;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end

                default: begin
                    tx_q    <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
